// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: accepts one clipped rectangle command and streams
// its pixels in raster order, one per clock, to the VGA pixel port.
module vga_rect_fill #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x0,
  input  logic [6:0] cmd_y0,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_color,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot,
  output logic       done
);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);
  localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_EMPTY} state_t;

  state_t     state;
  logic [7:0] x0_q;
  logic [7:0] x_end_q;
  logic [6:0] y_end_q;

  logic [8:0] x_sum_c;
  logic [8:0] y_sum_c;
  logic [7:0] x_end_c;
  logic [6:0] y_end_c;
  logic       empty_c;
  logic       accept_c;
  logic       row_end_c;
  logic       last_c;
  logic [7:0] x_next_c;
  logic [6:0] y_next_c;
  logic       next_last_c;

  // Clip at accept with 9-bit sums; the cursor itself is the output register.
  always_comb begin
    x_sum_c     = {1'b0, cmd_x0} + {1'b0, cmd_w} - 9'd1;
    y_sum_c     = {2'b0, cmd_y0} + {2'b0, cmd_h} - 9'd1;
    x_end_c     = (x_sum_c > X_MAX) ? X_MAX[7:0] : x_sum_c[7:0];
    y_end_c     = (y_sum_c > Y_MAX) ? Y_MAX[6:0] : y_sum_c[6:0];
    empty_c     = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                  ({1'b0, cmd_x0} >= X_LIM) || ({2'b0, cmd_y0} >= Y_LIM);
    accept_c    = cmd_valid && cmd_ready;
    row_end_c   = (VGA_X == x_end_q);
    last_c      = row_end_c && (VGA_Y == y_end_q);
    x_next_c    = row_end_c ? x0_q : VGA_X + 8'd1;
    y_next_c    = row_end_c ? VGA_Y + 7'd1 : VGA_Y;
    next_last_c = (x_next_c == x_end_q) && (y_next_c == y_end_q);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      x0_q      <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            cmd_ready <= 1'b0;
            if (empty_c) begin
              state <= S_EMPTY;
              done  <= 1'b1;
            end else begin
              state     <= S_DRAW;
              x0_q      <= cmd_x0;
              x_end_q   <= x_end_c;
              y_end_q   <= y_end_c;
              VGA_X     <= cmd_x0;
              VGA_Y     <= cmd_y0;
              VGA_COLOR <= cmd_color;
              plot      <= 1'b1;
              done      <= (x_end_c == cmd_x0) && (y_end_c == cmd_y0);
            end
          end
        end
        S_DRAW: begin
          if (last_c) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            plot      <= 1'b0;
            done      <= 1'b0;
          end else begin
            VGA_X <= x_next_c;
            VGA_Y <= y_next_c;
            done  <= next_last_c;
          end
        end
        S_EMPTY: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          done      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          plot      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: stimulus pushes expected pixel/done
// events, a negedge monitor pops and compares every output event.
module tb_vga_rect_fill;

  logic       CLOCK_50;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x0;
  logic [6:0] cmd_y0;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_color;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       done;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_plot = 1'b0;
  logic prev_done = 1'b0;

  vga_rect_fill dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot),
    .done     (done)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                          input logic d);
    exp_t e;
    e.plot = 1'b1; e.x = x; e.y = y; e.c = c; e.done = d;
    q.push_back(e);
  endtask

  task automatic push_empty();
    exp_t e;
    e.plot = 1'b0; e.x = '0; e.y = '0; e.c = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  // Monitor: every plot/done cycle must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      prev_plot = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", 32'(cmd_ready), 32'd1);
      if (prev_plot && !prev_done) chk("plot_gap", 32'(plot), 32'd1);
      if (plot || done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: plot=%0b done=%0b x=%0d y=%0d want=none at %0t",
                   plot, done, VGA_X, VGA_Y, $time);
        end else begin
          exp_t e;
          logic ok;
          e = q.pop_front();
          ok = (plot == e.plot) && (done == e.done) && (cmd_ready == 1'b0) &&
               (!e.plot || (VGA_X == e.x && VGA_Y == e.y && VGA_COLOR == e.c));
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL event: got plot=%0b x=%0d y=%0d c=%0d done=%0b rdy=%0b want plot=%0b x=%0d y=%0d c=%0d done=%0b rdy=0",
                     plot, VGA_X, VGA_Y, VGA_COLOR, done, cmd_ready,
                     e.plot, e.x, e.y, e.c, e.done);
          end
        end
      end
      prev_plot = plot;
      prev_done = done;
    end
  end

  // Issue one command and check the first cycle after acceptance.
  task automatic send(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] w,
                      input logic [6:0] h, input logic [2:0] c, input logic is_empty);
    int n = 0;
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("ready_wait", 32'(n < 100), 32'd1);
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("first_plot", 32'(plot), 32'(!is_empty));
    if (is_empty) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_ready_low", 32'(cmd_ready), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      #1 n++;
    end while (!(q.size() == 0 && cmd_ready && !plot && !done) && n < 25000);
    chk("idle_timeout", 32'(n < 25000), 32'd1);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    cmd_valid = 1'b1;
    cmd_x0 = 8'd3; cmd_y0 = 7'd4; cmd_w = 8'd2; cmd_h = 7'd2; cmd_color = 3'd6;

    // Reset held with a command offered
    repeat (3) @(negedge CLOCK_50);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xyc", {17'd0, VGA_X, VGA_Y, VGA_COLOR}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Basic fill
    push_pix(8'd10, 7'd5, 3'd5, 1'b0);
    push_pix(8'd11, 7'd5, 3'd5, 1'b0);
    push_pix(8'd12, 7'd5, 3'd5, 1'b0);
    push_pix(8'd10, 7'd6, 3'd5, 1'b0);
    push_pix(8'd11, 7'd6, 3'd5, 1'b0);
    push_pix(8'd12, 7'd6, 3'd5, 1'b1);
    send(8'd10, 7'd5, 8'd3, 7'd2, 3'd5, 1'b0);
    wait_idle();

    // Clipping at the bottom-right corner
    push_pix(8'd158, 7'd118, 3'd2, 1'b0);
    push_pix(8'd159, 7'd118, 3'd2, 1'b0);
    push_pix(8'd158, 7'd119, 3'd2, 1'b0);
    push_pix(8'd159, 7'd119, 3'd2, 1'b1);
    send(8'd158, 7'd118, 8'd4, 7'd4, 3'd2, 1'b0);
    wait_idle();

    // Off-screen x0 is empty
    push_empty();
    send(8'd200, 7'd0, 8'd10, 7'd1, 3'd4, 1'b1);
    wait_idle();

    // Zero width is empty
    push_empty();
    send(8'd20, 7'd20, 8'd0, 7'd7, 3'd1, 1'b1);
    wait_idle();

    // Full screen, then a waiting 1x1 command
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        push_pix(8'(x), 7'(y), 3'd7, 1'b0);
    q[q.size() - 1].done = 1'b1;
    push_pix(8'd1, 7'd1, 3'd3, 1'b1);
    cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_w = 8'd160; cmd_h = 7'd120; cmd_color = 3'd7;
    cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 cmd_x0 = 8'd1; cmd_y0 = 7'd1; cmd_w = 8'd1; cmd_h = 7'd1; cmd_color = 3'd3;
    @(negedge CLOCK_50);
    chk("fs_first", {23'd0, plot, VGA_X}, {23'd0, 1'b1, 8'd0});
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!(plot && done) && n < 20000);
    chk("fs_done_seen", 32'(n < 20000), 32'd1);
    chk("fs_cycles", 32'(n + 1), 32'd19200);
    @(negedge CLOCK_50);
    chk("b2b_gap", {30'd0, cmd_ready, plot}, {30'd0, 1'b1, 1'b0});
    @(negedge CLOCK_50);
    chk("b2b_pixel", {12'd0, plot, VGA_X, VGA_Y, VGA_COLOR, done},
        {12'd0, 1'b1, 8'd1, 7'd1, 3'd3, 1'b1});
    cmd_valid = 1'b0;
    wait_idle();

    // Reset during the third pixel of a 20x20 fill
    push_pix(8'd30, 7'd40, 3'd6, 1'b0);
    push_pix(8'd31, 7'd40, 3'd6, 1'b0);
    push_pix(8'd32, 7'd40, 3'd6, 1'b0);
    send(8'd30, 7'd40, 8'd20, 7'd20, 3'd6, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge CLOCK_50);
      #1 n++;
    end
    chk("mid_plot_before", {23'd0, plot, VGA_X}, {23'd0, 1'b1, 8'd32});
    #1 resetn = 1'b0;
    #1;
    chk("mid_async_drop", {30'd0, plot, done}, 32'd0);
    chk("mid_async_x", 32'(VGA_X), 32'd0);
    @(negedge CLOCK_50);
    #2 resetn = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    push_pix(8'd5, 7'd5, 3'd1, 1'b0);
    push_pix(8'd6, 7'd5, 3'd1, 1'b0);
    push_pix(8'd5, 7'd6, 3'd1, 1'b0);
    push_pix(8'd6, 7'd6, 3'd1, 1'b1);
    send(8'd5, 7'd5, 8'd2, 7'd2, 3'd1, 1'b0);
    wait_idle();

    repeat (3) @(negedge CLOCK_50);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle-fill drawing engine that sits directly upstream of the DESim VGA pixel port. It accepts one rectangle command at a time over a valid/ready handshake and clips it to the 160x120 screen. It then emits one pixel per clock in raster order on `VGA_X`/`VGA_Y`/`VGA_COLOR` with `plot` asserted. Demos use it in place of a free-running coordinate scanner, for example to clear the screen or draw filled boxes.

## Interface
Parameters:
- `SCREEN_W`, default 160: visible columns; x range 0..SCREEN_W-1.
- `SCREEN_H`, default 120: visible rows; y range 0..SCREEN_H-1.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high exactly when the state is IDLE.
- `cmd_x0`  in  8  left column.
- `cmd_y0`  in  7  top row.
- `cmd_w`  in  8  width in pixels; 0 means an empty command.
- `cmd_h`  in  7  height in pixels; 0 means an empty command.
- `cmd_color`  in  3  fill colour (0-7).
- `VGA_X`  out  8  pixel column (registered).
- `VGA_Y`  out  7  pixel row (registered).
- `VGA_COLOR`  out  3  pixel colour (registered).
- `plot`  out  1  pixel valid this cycle; the VGA model writes the pixel when this is high.
- `done`  out  1  one-cycle pulse marking command completion.

## Operation
- States: IDLE, DRAW, EMPTY. Reset state is IDLE.
- Accept: occurs when `cmd_valid && cmd_ready` at a rising edge. All `cmd_*` fields are latched at that edge; later input changes are ignored until the next accept.
- Clipping is computed at accept with 9-bit sums, so there is no overflow:
  - x_end = min(cmd_x0 + cmd_w - 1, SCREEN_W-1)
  - y_end = min(cmd_y0 + cmd_h - 1, SCREEN_H-1)
- Empty command: `cmd_w==0`, `cmd_h==0`, `cmd_x0>=SCREEN_W` or `cmd_y0>=SCREEN_H`.
  - IDLE -> EMPTY.
  - EMPTY lasts one cycle with `done`=1 and `plot`=0, then goes to IDLE.
- Non-empty command: IDLE -> DRAW, with the pixel cursor loaded to (x0, y0).
- DRAW, each cycle:
  - Output the cursor pixel with `plot`=1 and `VGA_COLOR`=latched colour.
  - Advance x. When x==x_end, reset x to x0 and increment y.
  - On the final pixel (x==x_end && y==y_end): `done`=1 in the same cycle, and the state goes to IDLE.
- When `plot`=0, `VGA_X`/`VGA_Y`/`VGA_COLOR` hold their last values.
- No backpressure from the VGA side; one pixel is emitted per cycle unconditionally.
- `cmd_valid` seen while not IDLE is ignored (`cmd_ready`=0). The command is not queued.

## Timing
- Reset values, applied immediately on `resetn` low regardless of clock: `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0, `plot`=0, `done`=0, state IDLE, so `cmd_ready`=1.
- Latency: the first pixel appears on outputs in the cycle after the accept edge.
- A non-empty rectangle of clipped size cw x ch:
  - `plot` is high for exactly cw*ch consecutive cycles.
  - `done` coincides with the last `plot` cycle.
  - `cmd_ready` rises the following cycle.
- Throughput: cw*ch+1 cycles per command when commands are presented back to back.
- Empty command: `done` is high in the cycle after accept, with no `plot`. `cmd_ready` is low for exactly that one cycle.
- Reset asserted mid-DRAW:
  - `plot` and `done` drop asynchronously.
  - The remaining pixels are abandoned; no resume.
  - After release, the block is in IDLE and accepts a new command.

## Test plan
- **Reset:** hold `resetn`=0, toggle the clock and drive `cmd_valid`=1. Required: `plot`=0, `done`=0, `VGA_X`/`VGA_Y`/`VGA_COLOR`=0, `cmd_ready`=1, and no accept occurs.
- **Basic fill:** send x0=10, y0=5, w=3, h=2, colour 5. Required: 6 `plot` cycles in the order (10,5), (11,5), (12,5), (10,6), (11,6), (12,6), all with `VGA_COLOR`=5. `done` is high on (12,6). `cmd_ready`=0 during the fill and 1 on the next cycle.
- **Clipping:** send x0=158, y0=118, w=4, h=4, colour 2. Required: exactly 4 pixels, (158,118), (159,118), (158,119), (159,119), then `done`.
  - Also send x0=200, w=10. Required: treated as empty.
- **Empty:** send w=0, h=7. Required: `plot` never asserts, `done`=1 in the cycle after accept, `cmd_ready` low for exactly 1 cycle.
- **Full screen / back-to-back:** send x0=0, y0=0, w=160, h=120, colour 7. Keep `cmd_valid` high with a second command x0=1, y0=1, w=1, h=1, colour 3 waiting.
  - Required: 19200 consecutive plots ending at (159,119) with `done`.
  - The second command is accepted on the next cycle and its pixel (1,1) colour 3 follows one cycle later.
  - Input changes made during the first fill have no effect on it.
- **Reset mid-fill:** assert `resetn`=0 at pixel 3 of a 20x20 fill. Required: `plot` drops with no clock edge needed. After release, no further pixels, `cmd_ready`=1, and a new command draws correctly.
